wave_sequencer: RTL and testbench

- Controller that sequences a single waveform generator through a programmable list of segments.
- Each segment holds an amplitude, a prescaler and a run length counted in output periods.
- Drives the generator's enable/amplitude/prescaler inputs and monitors its data output to count completed periods.
- Sits between the host configuration logic and the generator feeding the DAC path.

---
 rtl/wave_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_wave_sequencer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// wave_sequencer
//   Steps a single waveform generator through a programmable table of
//   segments. Each segment supplies an amplitude, a prescaler and a run
//   length counted in generator output periods (returns of gen_data to 0).
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cfg_we/cfg_addr   segment table write strobe and index
//   cfg_amplitude     segment amplitude
//   cfg_prescaler     segment prescaler
//   cfg_cycles        periods to run the segment (0 = skip)
//   cfg_last          segment terminates the list
//   start             begin the sequence at segment 0 (level, sampled in IDLE)
//   stop              abort the sequence, highest priority
//   loop_en           restart at segment 0 after the last segment
//   gen_data          generator output sample
//   gen_ena           generator enable (high only while a segment runs)
//   gen_amplitude     generator amplitude (holds its last value in IDLE)
//   gen_prescaler     generator prescaler (holds its last value in IDLE)
//   busy              high in every state except IDLE
//   seg_idx           current segment index
//   done              one-cycle pulse on normal completion
module wave_sequencer #(
  parameter int unsigned NUM_SEG = 4,
  parameter int unsigned SEG_W   = 2,
  parameter int unsigned DW      = 16,
  parameter int unsigned CW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [SEG_W-1:0] cfg_addr,
  input  logic [DW-1:0]    cfg_amplitude,
  input  logic [DW-1:0]    cfg_prescaler,
  input  logic [CW-1:0]    cfg_cycles,
  input  logic             cfg_last,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [DW-1:0]    gen_data,
  output logic             gen_ena,
  output logic [DW-1:0]    gen_amplitude,
  output logic [DW-1:0]    gen_prescaler,
  output logic             busy,
  output logic [SEG_W-1:0] seg_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_NEXT
  } state_e;

  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEG - 1);

  // Segment table
  logic [DW-1:0] tbl_amp_q [NUM_SEG];
  logic [DW-1:0] tbl_amp_d [NUM_SEG];
  logic [DW-1:0] tbl_pre_q [NUM_SEG];
  logic [DW-1:0] tbl_pre_d [NUM_SEG];
  logic [CW-1:0] tbl_cyc_q [NUM_SEG];
  logic [CW-1:0] tbl_cyc_d [NUM_SEG];
  logic          tbl_last_q [NUM_SEG];
  logic          tbl_last_d [NUM_SEG];

  // Sequencer state and the working copy of the active segment
  state_e           state_q, state_d;
  logic [SEG_W-1:0] seg_idx_q, seg_idx_d;
  logic [DW-1:0]    gen_amplitude_q, gen_amplitude_d;
  logic [DW-1:0]    gen_prescaler_q, gen_prescaler_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    prev_data_q, prev_data_d;
  logic             ran_flag_q, ran_flag_d;
  logic             done_q, done_d;

  logic             load_req;
  logic [SEG_W-1:0] load_idx;
  logic             wrap;
  logic [CW-1:0]    cnt_inc;

  // Table writes are accepted in every state; the running segment works
  // from its own copy, so rewriting it only matters at its next load.
  always_comb begin
    tbl_amp_d  = tbl_amp_q;
    tbl_pre_d  = tbl_pre_q;
    tbl_cyc_d  = tbl_cyc_q;
    tbl_last_d = tbl_last_q;
    if (cfg_we) begin
      tbl_amp_d[cfg_addr]  = cfg_amplitude;
      tbl_pre_d[cfg_addr]  = cfg_prescaler;
      tbl_cyc_d[cfg_addr]  = cfg_cycles;
      tbl_last_d[cfg_addr] = cfg_last;
    end
  end

  // A period ends when the sample falls back to zero from a non-zero value.
  assign wrap    = (prev_data_q != '0) && (gen_data == '0);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d         = state_q;
    seg_idx_d       = seg_idx_q;
    gen_amplitude_d = gen_amplitude_q;
    gen_prescaler_d = gen_prescaler_q;
    cycles_d        = cycles_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    prev_data_d     = prev_data_q;
    ran_flag_d      = ran_flag_q;
    done_d          = 1'b0;
    load_req        = 1'b0;
    load_idx        = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_LOAD;
          load_req   = 1'b1;
          load_idx   = '0;
          ran_flag_d = 1'b0;
        end
      end

      ST_LOAD: begin
        cnt_d       = '0;
        prev_data_d = gen_data;
        if ((gen_amplitude_q == '0) || (cycles_q == '0)) begin
          state_d = ST_NEXT;
        end else begin
          state_d    = ST_RUN;
          ran_flag_d = 1'b1;
        end
      end

      ST_RUN: begin
        prev_data_d = gen_data;
        if (wrap) begin
          cnt_d = cnt_inc;
          if (cnt_inc == cycles_q) begin
            state_d = ST_NEXT;
          end
        end
      end

      ST_NEXT: begin
        if (last_q || (seg_idx_q == SEG_LAST)) begin
          // A pass that ran nothing never loops, so an empty table terminates.
          if (loop_en && ran_flag_q) begin
            state_d    = ST_LOAD;
            load_req   = 1'b1;
            load_idx   = '0;
            ran_flag_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d  = ST_LOAD;
          load_req = 1'b1;
          load_idx = seg_idx_q + SEG_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && stop) begin
      state_d  = ST_IDLE;
      load_req = 1'b0;
      done_d   = 1'b0;
    end

    // The entry is captured on the edge into LOAD so the generator already
    // sees the new amplitude/prescaler during LOAD while gen_ena is low.
    if (load_req) begin
      seg_idx_d       = load_idx;
      gen_amplitude_d = tbl_amp_q[load_idx];
      gen_prescaler_d = tbl_pre_q[load_idx];
      cycles_d        = tbl_cyc_q[load_idx];
      last_d          = tbl_last_q[load_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SEG; i++) begin
        tbl_amp_q[i]  <= '0;
        tbl_pre_q[i]  <= '0;
        tbl_cyc_q[i]  <= '0;
        tbl_last_q[i] <= 1'b0;
      end
      state_q         <= ST_IDLE;
      seg_idx_q       <= '0;
      gen_amplitude_q <= '0;
      gen_prescaler_q <= '0;
      cycles_q        <= '0;
      last_q          <= 1'b0;
      cnt_q           <= '0;
      prev_data_q     <= '0;
      ran_flag_q      <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      tbl_amp_q       <= tbl_amp_d;
      tbl_pre_q       <= tbl_pre_d;
      tbl_cyc_q       <= tbl_cyc_d;
      tbl_last_q      <= tbl_last_d;
      state_q         <= state_d;
      seg_idx_q       <= seg_idx_d;
      gen_amplitude_q <= gen_amplitude_d;
      gen_prescaler_q <= gen_prescaler_d;
      cycles_q        <= cycles_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      prev_data_q     <= prev_data_d;
      ran_flag_q      <= ran_flag_d;
      done_q          <= done_d;
    end
  end

  assign gen_ena       = (state_q == ST_RUN);
  assign busy          = (state_q != ST_IDLE);
  assign gen_amplitude = gen_amplitude_q;
  assign gen_prescaler = gen_prescaler_q;
  assign seg_idx       = seg_idx_q;
  assign done          = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer
//   Drives wave_sequencer with directed and randomized segment tables, runs
//   a behavioural waveform generator on its outputs and compares the
//   observed segment runs against a list computed from the table contents.
module tb_wave_sequencer;

  localparam int unsigned NUM_SEG = 4;
  localparam int unsigned SEG_W   = 2;
  localparam int unsigned DW      = 16;
  localparam int unsigned CW      = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [SEG_W-1:0] cfg_addr = '0;
  logic [DW-1:0]    cfg_amplitude = '0;
  logic [DW-1:0]    cfg_prescaler = '0;
  logic [CW-1:0]    cfg_cycles = '0;
  logic             cfg_last = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic [DW-1:0]    gen_data = '0;
  logic             gen_ena;
  logic [DW-1:0]    gen_amplitude;
  logic [DW-1:0]    gen_prescaler;
  logic             busy;
  logic [SEG_W-1:0] seg_idx;
  logic             done;

  always #5 clk = ~clk;

  wave_sequencer #(
    .NUM_SEG(NUM_SEG),
    .SEG_W  (SEG_W),
    .DW     (DW),
    .CW     (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_amplitude(cfg_amplitude),
    .cfg_prescaler(cfg_prescaler),
    .cfg_cycles   (cfg_cycles),
    .cfg_last     (cfg_last),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .gen_data     (gen_data),
    .gen_ena      (gen_ena),
    .gen_amplitude(gen_amplitude),
    .gen_prescaler(gen_prescaler),
    .busy         (busy),
    .seg_idx      (seg_idx),
    .done         (done)
  );

  // Generator: ramps 0..amplitude, one step every prescaler+1 enabled
  // cycles; the prescale counter clears whenever it is disabled.
  logic          gen_clr = 1'b0;
  logic [DW-1:0] gen_pcnt = '0;
  always @(posedge clk) begin
    if (gen_clr) begin
      gen_data <= '0;
      gen_pcnt <= '0;
    end else if (!gen_ena) begin
      gen_pcnt <= '0;
    end else if (gen_pcnt == gen_prescaler) begin
      gen_pcnt <= '0;
      gen_data <= (gen_data == gen_amplitude) ? '0 : gen_data + 1'b1;
    end else begin
      gen_pcnt <= gen_pcnt + 1'b1;
    end
  end

  // Monitor: one record per gen_ena high interval
  typedef struct {
    int unsigned seg;
    int unsigned amp;
    int unsigned pre;
    int unsigned wraps;
    int unsigned load_amp;
    int unsigned gap;
    bit          moved;
    bit          end_wrap;
  } run_t;

  run_t          runs[$];
  run_t          cur;
  int unsigned   cyc_n = 0;
  int unsigned   done_n = 0;
  int unsigned   last_fall = 0;
  logic          ena_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  logic [DW-1:0] amp_prev = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc_n++;
      if (gen_ena && !ena_prev) begin
        cur.seg      = 32'(seg_idx);
        cur.amp      = 32'(gen_amplitude);
        cur.pre      = 32'(gen_prescaler);
        cur.wraps    = 0;
        cur.load_amp = 32'(amp_prev);
        cur.gap      = cyc_n - last_fall;
        cur.moved    = 1'b0;
        cur.end_wrap = 1'b0;
      end
      if (gen_ena) begin
        cur.end_wrap = (data_prev != '0) && (gen_data == '0);
        if (cur.end_wrap) cur.wraps++;
        if (32'(gen_amplitude) != cur.amp || 32'(gen_prescaler) != cur.pre) cur.moved = 1'b1;
      end else if (ena_prev) begin
        runs.push_back(cur);
        last_fall = cyc_n;
      end
      if (done) done_n++;
      ena_prev  = gen_ena;
      data_prev = gen_data;
      amp_prev  = gen_amplitude;
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Host-side copy of the table
  int unsigned t_amp[NUM_SEG];
  int unsigned t_pre[NUM_SEG];
  int unsigned t_cyc[NUM_SEG];
  bit          t_last[NUM_SEG];

  task automatic clear_mirror();
    for (int i = 0; i < NUM_SEG; i++) begin
      t_amp[i] = 0; t_pre[i] = 0; t_cyc[i] = 0; t_last[i] = 1'b0;
    end
  endtask

  task automatic write_seg(input int unsigned idx, input int unsigned amp, input int unsigned pre,
                           input int unsigned cyc, input bit last);
    cfg_addr      = SEG_W'(idx);
    cfg_amplitude = DW'(amp);
    cfg_prescaler = DW'(pre);
    cfg_cycles    = CW'(cyc);
    cfg_last      = last;
    cfg_we        = 1'b1;
    tick();
    cfg_we        = 1'b0;
    t_amp[idx] = amp; t_pre[idx] = pre; t_cyc[idx] = cyc; t_last[idx] = last;
  endtask

  task automatic gen_reset();
    gen_clr = 1'b1;
    tick();
    gen_clr = 1'b0;
  endtask

  typedef struct {
    int unsigned seg;
    int unsigned amp;
    int unsigned pre;
    int unsigned cyc;
    int unsigned gap;
  } exp_t;

  // Runs one sequence and compares every observed segment run with the
  // list derived from the table: which segments run, in what order, for
  // how many periods, how many idle cycles separate them, and whether
  // the sequence ends with done.
  task automatic run_seq(input bit loop, input int unsigned want, input string name,
                         output int unsigned lat);
    exp_t        eq[$];
    exp_t        e;
    int unsigned idx = 0;
    int unsigned skipped = 0;
    bit          ran = 1'b0;
    bit          fin = 1'b0;
    bit          edone = 1'b0;
    int unsigned base, dbase, n, obs;

    for (int it = 0; it < 1000 && !fin; it++) begin
      if (t_amp[idx] != 0 && t_cyc[idx] != 0) begin
        e.seg = idx; e.amp = t_amp[idx]; e.pre = t_pre[idx]; e.cyc = t_cyc[idx];
        e.gap = 2 + 2 * skipped;
        eq.push_back(e);
        skipped = 0;
        ran = 1'b1;
        if (loop && eq.size() >= want) fin = 1'b1;
      end else begin
        skipped++;
      end
      if (!fin) begin
        if (t_last[idx] || idx == NUM_SEG - 1) begin
          if (loop && ran) begin
            idx = 0;
            ran = 1'b0;
          end else begin
            edone = 1'b1;
            fin   = 1'b1;
          end
        end else begin
          idx++;
        end
      end
    end

    gen_reset();
    loop_en = loop;
    base    = runs.size();
    dbase   = done_n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    n = 0;
    while (!(busy == 1'b0 || (loop && runs.size() - base >= want)) && n < 5000) begin
      tick();
      n++;
    end
    lat = n;
    check_eq($sformatf("%s finished in time", name), 32'(n < 5000), 1);
    if (busy) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_eq($sformatf("%s busy after stop", name), 32'(busy), 0);
    end
    tick();
    check_eq($sformatf("%s done pulses", name), done_n - dbase, 32'(edone));
    check_eq($sformatf("%s busy at end", name), 32'(busy), 0);
    obs = runs.size() - base;
    check_eq($sformatf("%s run count", name), obs, eq.size());
    for (int i = 0; i < obs && i < eq.size(); i++) begin
      check_eq($sformatf("%s run%0d seg", name, i), runs[base+i].seg, eq[i].seg);
      check_eq($sformatf("%s run%0d amp", name, i), runs[base+i].amp, eq[i].amp);
      check_eq($sformatf("%s run%0d pre", name, i), runs[base+i].pre, eq[i].pre);
      check_eq($sformatf("%s run%0d periods", name, i), runs[base+i].wraps, eq[i].cyc);
      check_eq($sformatf("%s run%0d ends on wrap", name, i), 32'(runs[base+i].end_wrap), 1);
      check_eq($sformatf("%s run%0d outputs stable", name, i), 32'(runs[base+i].moved), 0);
      check_eq($sformatf("%s run%0d amp in LOAD", name, i), runs[base+i].load_amp, eq[i].amp);
      if (i > 0) check_eq($sformatf("%s run%0d idle gap", name, i), runs[base+i].gap, eq[i].gap);
    end
  endtask

  initial begin
    int unsigned lat, base, dbase, n;

    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat, base, dbase, n;

    clear_mirror();
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("reset gen_ena", 32'(gen_ena), 0);
    check_eq("reset busy", 32'(busy), 0);
    check_eq("reset done", 32'(done), 0);
    check_eq("reset seg_idx", 32'(seg_idx), 0);
    check_eq("reset gen_amplitude", 32'(gen_amplitude), 0);
    check_eq("reset gen_prescaler", 32'(gen_prescaler), 0);
    rst_n = 1'b1;
    tick();

    // Single segment, exact timing from start
    write_seg(0, 3, 0, 2, 1'b1);
    gen_reset();
    loop_en = 1'b0;
    base  = runs.size();
    dbase = done_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1 LOAD busy", 32'(busy), 1);
    check_eq("t1 LOAD gen_ena", 32'(gen_ena), 0);
    check_eq("t1 LOAD gen_amplitude", 32'(gen_amplitude), 3);
    tick();
    check_eq("t1 RUN gen_ena", 32'(gen_ena), 1);
    n = 1;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    // LOAD, 2 periods of 4 ramp steps plus the first RUN cycle, NEXT, IDLE
    check_eq("t1 start to done", n, 2 * 4 + 3);
    check_eq("t1 busy with done", 32'(busy), 0);
    tick();
    check_eq("t1 done one cycle", 32'(done), 0);
    check_eq("t1 done count", done_n - dbase, 1);
    check_eq("t1 run count", runs.size() - base, 1);
    if (runs.size() > base) check_eq("t1 periods", runs[base].wraps, 2);

    // Two consecutive segments
    write_seg(0, 2, 0, 1, 1'b0);
    write_seg(1, 5, 1, 1, 1'b1);
    run_seq(1'b0, 0, "t2", lat);

    // Skipped segments in front of a running one
    write_seg(0, 0, 1, 2, 1'b0);
    write_seg(1, 4, 0, 0, 1'b0);
    write_seg(2, 4, 0, 3, 1'b1);
    run_seq(1'b0, 0, "t3", lat);

    // Looping, then stop in the middle of a run
    write_seg(0, 1, 0, 1, 1'b1);
    run_seq(1'b1, 3, "t4 loop", lat);
    gen_reset();
    loop_en = 1'b1;
    dbase   = done_n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    n = 0;
    while (runs.size() < base + 1000 && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (!gen_ena && n < 100) begin
      tick();
      n++;
    end
    check_eq("t4 reached RUN", 32'(gen_ena), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("t4 stop gen_ena", 32'(gen_ena), 0);
    check_eq("t4 stop busy", 32'(busy), 0);
    tick();
    tick();
    check_eq("t4 stop no done", done_n - dbase, 0);

    // Write to the active segment while it runs
    write_seg(0, 3, 0, 2, 1'b1);
    gen_reset();
    loop_en = 1'b1;
    base    = runs.size();
    start   = 1'b1;
    tick();
    start   = 1'b0;
    n = 0;
    while (!gen_ena && n < 100) begin
      tick();
      n++;
    end
    write_seg(0, 7, 0, 2, 1'b1);
    check_eq("t7 still running", 32'(gen_ena), 1);
    check_eq("t7 amp held", 32'(gen_amplitude), 3);
    n = 0;
    while (runs.size() - base < 2 && n < 1000) begin
      tick();
      n++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("t7 run count", 32'(runs.size() - base >= 2), 1);
    if (runs.size() - base >= 2) begin
      check_eq("t7 first pass amp", runs[base].amp, 3);
      check_eq("t7 reload amp", runs[base+1].amp, 7);
      check_eq("t7 reload periods", runs[base+1].wraps, 2);
      check_eq("t7 first pass stable", 32'(runs[base].moved), 0);
    end

    // Asynchronous reset in the middle of a run
    write_seg(0, 3, 1, 3, 1'b1);
    gen_reset();
    loop_en = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    n = 0;
    while (!gen_ena && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6 rst gen_ena", 32'(gen_ena), 0);
    check_eq("t6 rst busy", 32'(busy), 0);
    check_eq("t6 rst gen_amplitude", 32'(gen_amplitude), 0);
    check_eq("t6 rst gen_prescaler", 32'(gen_prescaler), 0);
    check_eq("t6 rst seg_idx", 32'(seg_idx), 0);
    check_eq("t6 rst done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    clear_mirror();
    tick();

    // Empty table with loop_en: one pass of skips, then done
    run_seq(1'b1, 1, "t5 empty", lat);
    check_eq("t5 pass length", lat, 2 * NUM_SEG);

    // Randomized tables
    for (int r = 0; r < 20; r++) begin
      int unsigned want;
      bit          lp;
      for (int s = 0; s < NUM_SEG; s++) begin
        write_seg(s,
                  ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 5),
                  $urandom_range(0, 2),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0));
      end
      lp   = ($urandom_range(0, 1) == 1);
      want = $urandom_range(2, 5);
      run_seq(lp, want, $sformatf("rnd%0d", r), lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
